// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to a combinational instruction memory and
// registers each fetched word. Fetching stops on HALT_WORD and a branch resumes it.
module instruction_fetch #(
    parameter int                  ADDR_W    = 8,
    parameter int                  INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC  = 8'h00,
    parameter logic [INSTR_W-1:0]  HALT_WORD = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic [INSTR_W-1:0] instr_next;
    logic [ADDR_W-1:0]  if_pc_next;
    logic               valid_next;
    logic               halted_next;
    logic [15:0]        count_next;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            if_instr    <= '0;
            if_pc       <= '0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_instr    <= instr_next;
            if_pc       <= if_pc_next;
            if_valid    <= valid_next;
            halted      <= halted_next;
            fetch_count <= count_next;
        end
    end

    // A branch outranks stall and halt; the captured instruction is dropped, not replaced.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = if_instr;
        if_pc_next  = if_pc;
        valid_next  = if_valid;
        halted_next = halted;
        count_next  = fetch_count;
        if (branch_taken) begin
            state_next  = FETCH;
            pc_next     = branch_target;
            valid_next  = 1'b0;
            halted_next = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        instr_next = imem_instr;
                        if_pc_next = pc;
                        valid_next = 1'b1;
                        if (fetch_count != 16'hFFFF) begin
                            count_next = fetch_count + 16'd1;
                        end
                        // The halt word is delivered, but the PC parks on it.
                        if (imem_instr == HALT_WORD) begin
                            state_next  = HALTED;
                            halted_next = 1'b1;
                        end else begin
                            pc_next = pc + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    valid_next = 1'b0;
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural instruction memory, hand-computed
// expectations checked one cycle at a time through a single check task.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [7:0] pc,
                               input logic [15:0] instr, input logic [15:0] cnt);
        check({tag, "_pc"}, 32'(if_pc), 32'(pc));
        check({tag, "_instr"}, 32'(if_instr), 32'(instr));
        check({tag, "_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_count"}, 32'(fetch_count), 32'(cnt));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_pc"}, 32'(if_pc), 32'd0);
        check({tag, "_instr"}, 32'(if_instr), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_count"}, 32'(fetch_count), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    endtask

    initial begin
        logic [15:0] e;
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003;
        mem[3] = 16'h1004; mem[4] = 16'h1005; mem[5] = 16'hFFFF;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        step();
        step();
        check_reset("reset");

        // Sequential run with a 3-cycle stall after if_pc=1.
        rst_n = 1'b1;
        exp_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004};
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_q.pop_front();
            check_fetch("seq", 8'(i), e, 16'(i + 1));
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_fetch("stall_hold", 8'h01, 16'h1002, 16'd2);
            check("stall_addr", 32'(imem_addr), 32'd2);
        end
        stall = 1'b0;
        for (int i = 2; i < 4; i++) begin
            step();
            e = exp_q.pop_front();
            check_fetch("seq", 8'(i), e, 16'(i + 1));
        end

        // Halt word under stall must not halt; then halt on address 5.
        step();
        check_fetch("pre_halt", 8'h04, 16'h1005, 16'd5);
        stall = 1'b1;
        step();
        check("halt_under_stall", 32'(halted), 32'd0);
        check("halt_under_stall_count", 32'(fetch_count), 32'd5);
        stall = 1'b0;
        step();
        check_fetch("halt_word", 8'h05, 16'hFFFF, 16'd6);
        check("halt_set", 32'(halted), 32'd1);
        check("halt_addr", 32'(imem_addr), 32'd5);
        for (int k = 0; k < 10; k++) begin
            stall = k[0];
            step();
            check("halted_hold", 32'(halted), 32'd1);
            check("halted_valid", 32'(if_valid), 32'd0);
            check("halted_addr", 32'(imem_addr), 32'd5);
            check("halted_count", 32'(fetch_count), 32'd6);
        end
        stall = 1'b0;

        // Resume by branching to 0.
        branch_taken = 1'b1; branch_target = 8'h00;
        step();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_valid", 32'(if_valid), 32'd0);
        check("resume_addr", 32'(imem_addr), 32'd0);
        check("resume_pc_hold", 32'(if_pc), 32'd5);
        branch_taken = 1'b0;
        step();
        check_fetch("resume", 8'h00, 16'h1001, 16'd7);

        // Branch while stalled.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step();
        check("bstall_addr", 32'(imem_addr), 32'h40);
        check("bstall_valid", 32'(if_valid), 32'd0);
        check("bstall_pc_hold", 32'(if_pc), 32'd0);
        check("bstall_count", 32'(fetch_count), 32'd7);
        branch_taken = 1'b0; branch_target = 8'h99;
        step();
        check("bstall_addr2", 32'(imem_addr), 32'h40);
        check("bstall_valid2", 32'(if_valid), 32'd0);
        stall = 1'b0;
        step();
        check_fetch("bstall_target", 8'h40, 16'h2040, 16'd8);

        // PC wrap.
        branch_taken = 1'b1; branch_target = 8'hFE;
        step();
        check("wrap_valid", 32'(if_valid), 32'd0);
        check("wrap_addr", 32'(imem_addr), 32'hFE);
        branch_taken = 1'b0;
        step();
        check_fetch("wrap_fe", 8'hFE, 16'h20FE, 16'd9);
        step();
        check_fetch("wrap_ff", 8'hFF, 16'h20FF, 16'd10);
        step();
        check_fetch("wrap_00", 8'h00, 16'h1001, 16'd11);
        check("wrap_addr1", 32'(imem_addr), 32'd1);

        // Build a halted state with fetch_count=7, then reset over stall and branch.
        rst_n = 1'b0;
        step();
        check("rst_count", 32'(fetch_count), 32'd0);
        rst_n = 1'b1;
        step();
        check_fetch("rst_first", 8'h00, 16'h1001, 16'd1);
        branch_taken = 1'b1; branch_target = 8'h00;
        step();
        check("rebranch_valid", 32'(if_valid), 32'd0);
        branch_taken = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_fetch("refetch", 8'(i), mem[i], 16'(i + 2));
        end
        check("rehalt", 32'(halted), 32'd1);
        step();
        check("rehalt_valid", 32'(if_valid), 32'd0);
        rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h33;
        step();
        check_reset("mid_reset");
        rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        step();
        check_fetch("post_reset", 8'h00, 16'h1001, 16'd1);

        // Saturation of fetch_count.
        mem[5] = 16'h1006;
        for (int k = 0; k < 65540; k++) step();
        check("sat_count", 32'(fetch_count), 32'hFFFF);
        check("sat_valid", 32'(if_valid), 32'd1);
        step();
        check("sat_hold", 32'(fetch_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
